// File: rtl/fp_align_pipe_if.sv
// Valid/ready operand and result bundle for the two-stage floating-point operand aligner.
interface fp_align_pipe_if #(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 25
);
  logic             in_valid;
  logic             in_ready;
  logic [EXP_W-1:0] exp_a;
  logic [EXP_W-1:0] exp_b;
  logic [MAN_W-1:0] man_a;
  logic [MAN_W-1:0] man_b;
  logic             out_valid;
  logic             out_ready;
  logic [EXP_W-1:0] exp_o;
  logic [MAN_W-1:0] big_o;
  logic [MAN_W+1:0] small_o;
  logic             sticky_o;
  logic             swap_o;

  modport master (
    output in_valid, exp_a, exp_b, man_a, man_b, out_ready,
    input  in_ready, out_valid, exp_o, big_o, small_o, sticky_o, swap_o
  );

  modport slave (
    input  in_valid, exp_a, exp_b, man_a, man_b, out_ready,
    output in_ready, out_valid, exp_o, big_o, small_o, sticky_o, swap_o
  );
endinterface

// File: rtl/fp_align_pipe.sv
// Two-stage operand aligner: S1 picks the larger exponent and shift amount, S2 shifts the smaller mantissa.
// Define FP_ALIGN_STICKY_EN to build the sticky logic; otherwise sticky_o is tied low.
module fp_align_pipe #(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 25
) (
  input logic             clk,
  input logic             rst,
  fp_align_pipe_if.slave  bus
);
  localparam int unsigned XW   = MAN_W + 2;
  localparam int unsigned SH_W = $clog2(MAN_W + 3);

  logic             v1, v2;
  logic             load1, adv2;

  logic             sw_c;
  logic [EXP_W-1:0] exp_c, diff_c;
  logic [MAN_W-1:0] big_c, sml_c;
  logic [SH_W-1:0]  sh_c;

  logic             sw1;
  logic [EXP_W-1:0] exp1;
  logic [MAN_W-1:0] big1, sml1;
  logic [SH_W-1:0]  sh1;

  logic [XW-1:0]    ext, small_c;
  logic             sticky_c;

  logic             sw2, sticky2;
  logic [EXP_W-1:0] exp2;
  logic [MAN_W-1:0] big2;
  logic [XW-1:0]    small2;

  assign adv2         = v1 && (!v2 || bus.out_ready);
  assign bus.in_ready = !v1 || !v2 || bus.out_ready;
  assign load1        = bus.in_valid && bus.in_ready;

  always_comb begin
    sw_c = bus.exp_a > bus.exp_b;
    if (sw_c) begin
      exp_c  = bus.exp_a;
      diff_c = bus.exp_a - bus.exp_b;
      big_c  = bus.man_a;
      sml_c  = bus.man_b;
    end else begin
      exp_c  = bus.exp_b;
      diff_c = bus.exp_b - bus.exp_a;
      big_c  = bus.man_b;
      sml_c  = bus.man_a;
    end
    // Any difference of XW or more shifts everything out, so clamp to XW.
    if (32'(diff_c) >= XW) sh_c = SH_W'(XW);
    else                   sh_c = SH_W'(diff_c);
  end

  always_comb begin
    ext     = {sml1, 2'b00};
    small_c = ext >> sh1;
`ifdef FP_ALIGN_STICKY_EN
    sticky_c = |(ext & ~({XW{1'b1}} << sh1));
`else
    sticky_c = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1      <= 1'b0;
      v2      <= 1'b0;
      sw1     <= 1'b0;
      exp1    <= '0;
      big1    <= '0;
      sml1    <= '0;
      sh1     <= '0;
      sw2     <= 1'b0;
      sticky2 <= 1'b0;
      exp2    <= '0;
      big2    <= '0;
      small2  <= '0;
    end else begin
      if (load1) begin
        v1   <= 1'b1;
        sw1  <= sw_c;
        exp1 <= exp_c;
        big1 <= big_c;
        sml1 <= sml_c;
        sh1  <= sh_c;
      end else if (adv2) begin
        v1 <= 1'b0;
      end

      if (adv2) begin
        v2      <= 1'b1;
        sw2     <= sw1;
        exp2    <= exp1;
        big2    <= big1;
        small2  <= small_c;
        sticky2 <= sticky_c;
      end else if (bus.out_ready) begin
        v2 <= 1'b0;
      end
    end
  end

  assign bus.out_valid = v2;
  assign bus.exp_o     = exp2;
  assign bus.big_o     = big2;
  assign bus.small_o   = small2;
  assign bus.sticky_o  = sticky2;
  assign bus.swap_o    = sw2;
endmodule

// File: tb/tb_fp_align_pipe.sv
// Self-checking bench for fp_align_pipe: directed vectors, random streams with a queue-based reference model.
module tb_fp_align_pipe;
  localparam int unsigned EXP_W = 8;
  localparam int unsigned MAN_W = 25;
`ifdef FP_ALIGN_STICKY_EN
  localparam bit STICKY_EN = 1'b1;
`else
  localparam bit STICKY_EN = 1'b0;
`endif

  typedef struct packed {
    logic [7:0]  e;
    logic        sw;
    logic [24:0] big;
    logic [26:0] sm;
    logic        st;
  } res_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  int   out_count = 0;
  res_t q[$];

  always #5 clk = ~clk;

  fp_align_pipe_if #(.EXP_W(EXP_W), .MAN_W(MAN_W)) bus ();
  fp_align_pipe #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  function automatic res_t ref_model(input logic [7:0] ea, input logic [7:0] eb,
                                     input logic [24:0] ma, input logic [24:0] mb);
    res_t r;
    longint unsigned d, ext, p;
    r.sw  = ea > eb;
    r.e   = r.sw ? ea : eb;
    d     = r.sw ? longint'(ea) - longint'(eb) : longint'(eb) - longint'(ea);
    r.big = r.sw ? ma : mb;
    ext   = longint'(r.sw ? mb : ma) * 4;
    if (d >= 27) begin
      r.sm = '0;
      r.st = ext != 0;
    end else begin
      p    = 64'd1 << d;
      r.sm = 27'(ext / p);
      r.st = (ext % p) != 0;
    end
    if (!STICKY_EN) r.st = 1'b0;
    return r;
  endfunction

  function automatic res_t observed();
    res_t r;
    r.e = bus.exp_o; r.sw = bus.swap_o; r.big = bus.big_o; r.sm = bus.small_o; r.st = bus.sticky_o;
    return r;
  endfunction

  // Scoreboard: every output transfer must match the oldest accepted input.
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
    end else begin
      if (bus.out_valid && bus.out_ready) begin
        res_t exp_r, obs_r;
        out_count++;
        checks++;
        obs_r = observed();
        if (q.size() == 0) begin
          failures++;
          $display("FAIL scoreboard_spurious: got output %h with nothing outstanding", obs_r);
        end else begin
          exp_r = q.pop_front();
          if (obs_r !== exp_r) begin
            failures++;
            $display("FAIL scoreboard_data: got %h expected %h", obs_r, exp_r);
          end
        end
      end
      if (bus.in_valid && bus.in_ready)
        q.push_back(ref_model(bus.exp_a, bus.exp_b, bus.man_a, bus.man_b));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_random();
    logic [7:0] ea;
    ea = 8'($urandom);
    bus.exp_a = ea;
    case ($urandom_range(0, 3))
      0:       bus.exp_b = ea;
      1:       bus.exp_b = ea + 8'($urandom_range(0, 30));
      2:       bus.exp_b = ea - 8'($urandom_range(0, 30));
      default: bus.exp_b = 8'($urandom);
    endcase
    bus.man_a = ($urandom_range(0, 7) == 0) ? '0 : 25'($urandom);
    bus.man_b = ($urandom_range(0, 7) == 0) ? '0 : 25'($urandom);
  endtask

  task automatic test_reset();
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_handshake: out_valid=%b in_ready=%b expected 0/1", bus.out_valid, bus.in_ready);
    end
    checks++;
    if (observed() !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got %h expected 0", observed());
    end
  endtask

  task automatic test_directed(input string nm, input logic [7:0] ea, input logic [7:0] eb,
                               input logic [24:0] ma, input logic [24:0] mb,
                               input logic [7:0] xe, input logic xsw, input logic [24:0] xbig,
                               input logic [26:0] xsm, input logic xst);
    res_t want;
    want.e = xe; want.sw = xsw; want.big = xbig; want.sm = xsm; want.st = xst & STICKY_EN;
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1;
    bus.exp_a = ea; bus.exp_b = eb; bus.man_a = ma; bus.man_b = mb;
    tick();
    bus.in_valid = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL %s_latency_early: out_valid=%b expected 0 one cycle after transfer", nm, bus.out_valid);
    end
    tick();
    checks++;
    if (bus.out_valid !== 1'b1) begin
      failures++;
      $display("FAIL %s_latency: out_valid=%b expected 1 two cycles after transfer", nm, bus.out_valid);
    end
    checks++;
    if (observed() !== want) begin
      failures++;
      $display("FAIL %s_value: got %h expected %h", nm, observed(), want);
    end
    tick();
  endtask

  task automatic test_alignment();
    test_directed("basic",   8'h85, 8'h82, 25'h1000000, 25'h1800000, 8'h85, 1'b1, 25'h1000000, 27'h0C00000, 1'b0);
    test_directed("equal",   8'h7F, 8'h7F, 25'h1234567, 25'h0ABCDEF, 8'h7F, 1'b0, 25'h0ABCDEF, 27'h48D159C, 1'b0);
    test_directed("sat",     8'h80, 8'h9E, 25'h0000001, 25'h1000000, 8'h9E, 1'b0, 25'h1000000, 27'h0,       1'b1);
    test_directed("partial", 8'h80, 8'h9A, 25'h1000001, 25'h1555555, 8'h9A, 1'b0, 25'h1555555, 27'h1,       1'b1);
    test_directed("diff27",  8'hA0, 8'h85, 25'h1ABCDEF, 25'h1FFFFFF, 8'hA0, 1'b1, 25'h1ABCDEF, 27'h0,       1'b1);
    test_directed("diff25",  8'h99, 8'h80, 25'h0F0F0F0, 25'h1FFFFFF, 8'h99, 1'b1, 25'h0F0F0F0, 27'h3,       1'b1);
    test_directed("zero",    8'h90, 8'h85, 25'h1ABCDEF, 25'h0,       8'h90, 1'b1, 25'h1ABCDEF, 27'h0,       1'b0);
  endtask

  task automatic test_stream(input string nm, input int n, input bit stall);
    int sent = 0;
    int cyc = 0;
    int base = out_count;
    while (sent < n && cyc < 5000) begin
      bus.out_ready = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
      bus.in_valid  = stall ? ($urandom_range(0, 4) != 0) : 1'b1;
      drive_random();
      #1;
      if (bus.in_valid && bus.in_ready) sent++;
      tick();
      cyc++;
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    if (!stall) begin
      checks++;
      if (cyc != n) begin
        failures++;
        $display("FAIL %s_throughput: took %0d cycles expected %0d", nm, cyc, n);
      end
    end
    while (out_count < base + n && cyc < 5100) begin
      tick();
      cyc++;
    end
    checks++;
    if (out_count != base + n || q.size() != 0) begin
      failures++;
      $display("FAIL %s_count: got %0d outputs (%0d pending) expected %0d", nm, out_count - base, q.size(), n);
    end
  endtask

  task automatic test_back_to_back();
    test_stream("b2b", 200, 1'b0);
  endtask

  task automatic test_random_stall();
    test_stream("stall", 300, 1'b1);
  endtask

  task automatic test_backpressure();
    int idx = 0;
    int cyc = 0;
    int stall_left = 3;
    int base = out_count;
    bit started = 1'b0;
    res_t held;
    bus.out_ready = 1'b1;
    while ((idx < 4 || out_count < base + 4) && cyc < 100) begin
      if (bus.out_valid && !started) begin
        started = 1'b1;
        held = observed();
      end
      if (started && stall_left > 0) begin
        bus.out_ready = 1'b0;
        if (stall_left < 3) begin
          checks++;
          if (bus.out_valid !== 1'b1 || observed() !== held) begin
            failures++;
            $display("FAIL bp_hold: valid=%b got %h expected %h", bus.out_valid, observed(), held);
          end
        end
        stall_left--;
      end else begin
        bus.out_ready = 1'b1;
      end
      bus.in_valid = idx < 4;
      drive_random();
      #1;
      if (started && stall_left == 2) begin
        checks++;
        if (bus.in_ready !== 1'b0) begin
          failures++;
          $display("FAIL bp_in_ready: in_ready=%b expected 0 with both stages full", bus.in_ready);
        end
      end
      if (bus.in_valid && bus.in_ready) idx++;
      tick();
      cyc++;
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    checks++;
    if (out_count != base + 4 || q.size() != 0) begin
      failures++;
      $display("FAIL bp_count: got %0d outputs (%0d pending) expected 4", out_count - base, q.size());
    end
  endtask

  task automatic test_reset_midstream();
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    drive_random();
    tick();
    drive_random();
    tick();
    bus.in_valid = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
      failures++;
      $display("FAIL mid_full: out_valid=%b in_ready=%b expected 1/0", bus.out_valid, bus.in_ready);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.out_ready = 1'b1;
    test_reset();
    test_directed("post_rst", 8'h85, 8'h82, 25'h1000000, 25'h1800000, 8'h85, 1'b1, 25'h1000000, 27'h0C00000, 1'b0);
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    bus.exp_a = '0; bus.exp_b = '0; bus.man_a = '0; bus.man_b = '0;
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    #1;
    test_reset();
    test_alignment();
    test_back_to_back();
    test_backpressure();
    test_random_stall();
    test_reset_midstream();
    repeat (3) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
